// File: rtl/uart.sv
// Byte-lane UART: 8N1 transmitter with one holding byte, receiver with one buffer byte.
// Four registers in two halfwords: DATA/STATUS and DIVLO/DIVHI+tx_ie.
module uart #(
    parameter logic [15:0] BASE      = 16'h0010,
    parameter logic [15:0] DIV_RESET = 16'd103
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [14:0] write_addr_even,
    input  logic [14:0] write_addr_odd,
    input  logic [7:0]  write_data_even,
    input  logic [7:0]  write_data_odd,
    input  logic        write_en_even,
    input  logic        write_en_odd,
    input  logic [14:0] read_addr_even,
    input  logic [14:0] read_addr_odd,
    output logic [7:0]  read_data_even,
    output logic [7:0]  read_data_odd,
    input  logic        rxd,
    output logic        txd,
    output logic        irq
);

    localparam logic [14:0] HA0 = BASE[15:1];
    localparam logic [14:0] HA1 = BASE[15:1] + 15'd1;

    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT
    } rx_state_t;

    logic [14:0] divisor;
    logic        tx_ie;

    tx_state_t   tx_state;
    logic [7:0]  tx_hold;
    logic [9:0]  tx_sh;
    logic [14:0] tx_div;
    logic [14:0] tx_cnt;
    logic [3:0]  tx_bit;
    logic        tx_full;
    logic        tx_busy;
    logic        txd_q;

    rx_state_t   rx_state;
    logic        rx_s1;
    logic        rx_s2;
    logic        rx_prev;
    logic [14:0] rx_div;
    logic [14:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_sh;
    logic [7:0]  rx_buf;
    logic        rx_valid;
    logic        rx_overrun;
    logic        rx_ferr;

    logic        dat_we;
    logic        divlo_we;
    logic        divhi_we;
    logic        pop;
    logic        stat_rd;
    logic        tx_empty;
    logic        tx_tick;
    logic        tx_last;
    logic        tx_load;
    logic        rx_tick;
    logic        rx_done;
    logic        rx_bad;
    logic [15:0] rx_half;
    logic [7:0]  status;

    assign dat_we   = write_en_even && (write_addr_even == HA0);
    assign divlo_we = write_en_even && (write_addr_even == HA1);
    assign divhi_we = write_en_odd && (write_addr_odd == HA1);
    assign pop      = (read_addr_even == HA0);
    assign stat_rd  = (read_addr_odd == HA0);

    assign tx_empty = !tx_busy && !tx_full;
    assign status   = {2'b00, tx_empty, rx_ferr, rx_overrun,
                       rx_valid, tx_full, tx_busy};
    assign irq      = rx_valid | (tx_empty & tx_ie);
    assign txd      = txd_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            divisor <= DIV_RESET[14:0];
            tx_ie   <= 1'b0;
        end else begin
            if (divlo_we)
                divisor[7:0] <= write_data_even;
            if (divhi_we) begin
                divisor[14:8] <= write_data_odd[6:0];
                tx_ie         <= write_data_odd[7];
            end
        end
    end

    // Reload straight from the stop bit so consecutive bytes abut.
    assign tx_tick = (tx_cnt == tx_div);
    assign tx_last = (tx_bit == 4'd9);
    assign tx_load = tx_full &&
                     ((tx_state == TX_IDLE) || (tx_tick && tx_last));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= TX_IDLE;
            tx_hold  <= 8'h00;
            tx_sh    <= 10'h3ff;
            tx_div   <= 15'd0;
            tx_cnt   <= 15'd0;
            tx_bit   <= 4'd0;
            tx_full  <= 1'b0;
            tx_busy  <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            if (dat_we && !tx_full) begin
                tx_hold <= write_data_even;
                tx_full <= 1'b1;
            end
            if (tx_load) begin
                tx_state <= TX_SHIFT;
                tx_sh    <= {1'b1, tx_hold, 1'b0};
                txd_q    <= 1'b0;
                tx_full  <= 1'b0;
                tx_busy  <= 1'b1;
                tx_bit   <= 4'd0;
                tx_cnt   <= 15'd0;
                tx_div   <= divisor;
            end else if (tx_state == TX_SHIFT) begin
                if (tx_tick) begin
                    tx_cnt <= 15'd0;
                    tx_div <= divisor;
                    if (tx_last) begin
                        tx_state <= TX_IDLE;
                        tx_busy  <= 1'b0;
                        txd_q    <= 1'b1;
                    end else begin
                        tx_bit <= tx_bit + 4'd1;
                        tx_sh  <= {1'b1, tx_sh[9:1]};
                        txd_q  <= tx_sh[1];
                    end
                end else begin
                    tx_cnt <= tx_cnt + 15'd1;
                end
            end
        end
    end

    assign rx_half = ({1'b0, rx_div} + 16'd1) >> 1;
    assign rx_tick = (rx_cnt == rx_div);
    assign rx_done = (rx_state == RX_STOP) && rx_tick && rx_s2;
    assign rx_bad  = (rx_state == RX_STOP) && rx_tick && !rx_s2;

    // Sync flops reset low so a start bit needs a high sample first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state   <= RX_IDLE;
            rx_s1      <= 1'b0;
            rx_s2      <= 1'b0;
            rx_prev    <= 1'b0;
            rx_div     <= 15'd0;
            rx_cnt     <= 15'd0;
            rx_bit     <= 3'd0;
            rx_sh      <= 8'h00;
            rx_buf     <= 8'h00;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            rx_ferr    <= 1'b0;
        end else begin
            rx_s1   <= rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            unique case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_state <= RX_START;
                        rx_cnt   <= 15'd0;
                        rx_div   <= divisor;
                    end
                end
                RX_START: begin
                    if ({1'b0, rx_cnt} == rx_half) begin
                        rx_cnt   <= 15'd0;
                        rx_div   <= divisor;
                        rx_bit   <= 3'd0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 15'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_cnt <= 15'd0;
                        rx_div <= divisor;
                        rx_sh  <= {rx_s2, rx_sh[7:1]};
                        rx_bit <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7)
                            rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 15'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_tick) begin
                        rx_cnt   <= 15'd0;
                        rx_div   <= divisor;
                        rx_state <= rx_s2 ? RX_IDLE : RX_WAIT;
                    end else begin
                        rx_cnt <= rx_cnt + 15'd1;
                    end
                end
                RX_WAIT: begin
                    if (rx_s2)
                        rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
            if (rx_done) begin
                rx_buf   <= rx_sh;
                rx_valid <= 1'b1;
            end else if (pop) begin
                rx_valid <= 1'b0;
            end
            if (rx_done && rx_valid && !pop)
                rx_overrun <= 1'b1;
            else if (stat_rd)
                rx_overrun <= 1'b0;
            if (rx_bad)
                rx_ferr <= 1'b1;
            else if (stat_rd)
                rx_ferr <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data_even <= 8'h00;
            read_data_odd  <= 8'h00;
        end else begin
            if (pop)
                read_data_even <= rx_buf;
            else if (read_addr_even == HA1)
                read_data_even <= divisor[7:0];
            else
                read_data_even <= 8'h00;
            if (stat_rd)
                read_data_odd <= status;
            else if (read_addr_odd == HA1)
                read_data_odd <= {tx_ie, divisor[14:8]};
            else
                read_data_odd <= 8'h00;
        end
    end

endmodule
